// File: rtl/bsm_pkg.sv
// Shared constants and state type for the bit-scan memory block.
package bsm_pkg;

    localparam int N_REG      = 16;
    localparam int REG_W      = 4;
    localparam int FRAME_BITS = 64;
    localparam int ADDR_W     = 4;
    localparam int BIT_W      = 2;
    localparam int POS_W      = 6;
    localparam int ACC_W      = 7;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic logic [POS_W-1:0] pos_of(input logic [ADDR_W-1:0] reg_a,
                                                input logic [BIT_W-1:0]  bit_sel);
        return {reg_a, bit_sel};
    endfunction

endpackage

// File: rtl/bsm_regfile.sv
// 16 x 4 register file with one write port and a combinational single-bit read.
module bsm_regfile
    import bsm_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [REG_W-1:0]  wd,
    input  logic [ADDR_W-1:0] rd_reg,
    input  logic [BIT_W-1:0]  rd_sel,
    output logic              rd_bit
);

    logic [REG_W-1:0] mem_q [N_REG];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < N_REG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[wa] <= wd;
        end
    end

    // Read sees the stored value, so a same-cycle write is not visible yet.
    assign rd_bit = mem_q[rd_reg][rd_sel];

endmodule

// File: rtl/bit_scan_mem.sv
// Bit-scan memory: samples one bit per strobe and counts ones over 64-position frames.
// Optional frame parity output enabled by defining FRAME_PARITY_EN.
module bit_scan_mem
    import bsm_pkg::*;
#(
    parameter int CNT_W = 7
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [REG_W-1:0]  wd,
    input  logic              adv,
    input  logic [ADDR_W-1:0] rg_a,
    input  logic [BIT_W-1:0]  bit_a,
    output logic              dout,
    output logic              dout_vld,
    output logic              frame_done,
    output logic [CNT_W-1:0]  ones_cnt,
    output logic              seq_err,
    output logic              state_dbg
`ifdef FRAME_PARITY_EN
    ,
    output logic              frame_par
`endif
);

    localparam int unsigned CNT_MAX = (CNT_W >= 32) ? 32'hFFFF_FFFF
                                                    : ((32'd1 << CNT_W) - 32'd1);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [POS_W-1:0]   p_q, p_d;
    logic [CNT_W-1:0]   ones_q, ones_d;
    logic               dout_q, dout_d;
    logic               vld_q, vld_d;
    logic               done_q, done_d;
    logic               seq_err_q, seq_err_d;
    logic               par_q, par_d;

    logic               sel_bit;
    logic [POS_W-1:0]   p;
    logic [POS_W-1:0]   p_next;
    logic [ACC_W-1:0]   total;

    bsm_regfile u_regfile (
        .clk    (clk),
        .clr    (clr),
        .we     (we),
        .wa     (wa),
        .wd     (wd),
        .rd_reg (rg_a),
        .rd_sel (bit_a),
        .rd_bit (sel_bit)
    );

    assign p      = pos_of(rg_a, bit_a);
    assign p_next = p_q + POS_W'(1);
    assign total  = acc_q + ACC_W'(sel_bit);

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        p_d       = p_q;
        ones_d    = ones_q;
        dout_d    = dout_q;
        vld_d     = adv;
        done_d    = 1'b0;
        seq_err_d = seq_err_q;
        par_d     = par_q;
        if (adv) begin
            dout_d = sel_bit;
            p_d    = p;
            case (state_q)
                IDLE: begin
                    if (p == '0) begin
                        state_d = RUN;
                        acc_d   = ACC_W'(sel_bit);
                    end
                end
                RUN: begin
                    if (p == p_next) begin
                        if (p == POS_W'(FRAME_BITS - 1)) begin
                            done_d = 1'b1;
                            acc_d  = '0;
                            par_d  = total[0];
                            if (CNT_W < ACC_W && 32'(total) > CNT_MAX) begin
                                ones_d = '1;
                            end else begin
                                ones_d = CNT_W'(total);
                            end
                        end else begin
                            acc_d = total;
                        end
                    end else begin
                        // Broken sequence: drop the partial frame; p=0 starts a fresh one.
                        seq_err_d = 1'b1;
                        if (p == '0) begin
                            state_d = RUN;
                            acc_d   = ACC_W'(sel_bit);
                        end else begin
                            state_d = IDLE;
                            acc_d   = '0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            p_q       <= '0;
            ones_q    <= '0;
            dout_q    <= 1'b0;
            vld_q     <= 1'b0;
            done_q    <= 1'b0;
            seq_err_q <= 1'b0;
            par_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            p_q       <= p_d;
            ones_q    <= ones_d;
            dout_q    <= dout_d;
            vld_q     <= vld_d;
            done_q    <= done_d;
            seq_err_q <= seq_err_d;
            par_q     <= par_d;
        end
    end

    assign dout       = dout_q;
    assign dout_vld   = vld_q;
    assign frame_done = done_q;
    assign ones_cnt   = ones_q;
    assign seq_err    = seq_err_q;
    assign state_dbg  = state_q;

`ifdef FRAME_PARITY_EN
    assign frame_par = par_q;
`else
    logic unused_par;
    assign unused_par = par_q;
`endif

endmodule

// File: tb/tb_bit_scan_mem.sv
// Directed self-checking bench for bit_scan_mem.
module tb_bit_scan_mem;

    logic       clk;
    logic       clr;
    logic       we;
    logic [3:0] wa;
    logic [3:0] wd;
    logic       adv;
    logic [3:0] rg_a;
    logic [1:0] bit_a;
    logic       dout;
    logic       dout_vld;
    logic       frame_done;
    logic [6:0] ones_cnt;
    logic       seq_err;
    logic       state_dbg;
`ifdef FRAME_PARITY_EN
    logic       frame_par;
`endif

    logic [3:0] mem_m [16];
    int         checks;
    int         errors;

    bit_scan_mem #(.CNT_W(7)) dut (
        .clk        (clk),
        .clr        (clr),
        .we         (we),
        .wa         (wa),
        .wd         (wd),
        .adv        (adv),
        .rg_a       (rg_a),
        .bit_a      (bit_a),
        .dout       (dout),
        .dout_vld   (dout_vld),
        .frame_done (frame_done),
        .ones_cnt   (ones_cnt),
        .seq_err    (seq_err),
        .state_dbg  (state_dbg)
`ifdef FRAME_PARITY_EN
        ,
        .frame_par  (frame_par)
`endif
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic wr(input int a, input logic [3:0] d);
        we = 1'b1;
        wa = 4'(a);
        wd = d;
        @(posedge clk);
        #1;
        we = 1'b0;
        mem_m[a] = d;
    endtask

    // Sample position p; optional same-cycle write to register wr_a.
    task automatic samp_w(input int p, input logic exp_done, input logic do_wr,
                          input int wr_a, input logic [3:0] wr_d);
        logic [3:0] r;
        logic       exp_d;
        r     = mem_m[p / 4];
        exp_d = r[p % 4];
        rg_a  = 4'(p / 4);
        bit_a = 2'(p % 4);
        adv   = 1'b1;
        if (do_wr) begin
            we = 1'b1;
            wa = 4'(wr_a);
            wd = wr_d;
        end
        @(posedge clk);
        #1;
        adv = 1'b0;
        we  = 1'b0;
        if (do_wr) mem_m[wr_a] = wr_d;
        chk($sformatf("dout p%0d", p), 32'(dout), 32'(exp_d));
        chk($sformatf("vld p%0d", p), 32'(dout_vld), 32'd1);
        chk($sformatf("done p%0d", p), 32'(frame_done), 32'(exp_done));
    endtask

    task automatic samp(input int p, input logic exp_done);
        samp_w(p, exp_done, 1'b0, 0, 4'h0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 16; i++) mem_m[i] = 4'h0;
        clr = 1'b1; we = 1'b0; wa = '0; wd = '0; adv = 1'b0; rg_a = '0; bit_a = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst dout", 32'(dout), 32'd0);
        chk("rst vld", 32'(dout_vld), 32'd0);
        chk("rst done", 32'(frame_done), 32'd0);
        chk("rst ones", 32'(ones_cnt), 32'd0);
        chk("rst seq_err", 32'(seq_err), 32'd0);
        chk("rst state", 32'(state_dbg), 32'd0);
        clr = 1'b0;
        @(posedge clk);
        #1;

        // all ones frame
        for (int i = 0; i < 16; i++) wr(i, 4'hF);
        for (int p = 0; p < 64; p++) samp(p, p == 63);
        chk("all1 ones", 32'(ones_cnt), 32'd64);
`ifdef FRAME_PARITY_EN
        chk("all1 par", 32'(frame_par), 32'd0);
`endif
        chk("all1 state", 32'(state_dbg), 32'd1);
        @(posedge clk);
        #1;
        chk("idle vld", 32'(dout_vld), 32'd0);
        chk("idle done", 32'(frame_done), 32'd0);
        chk("idle dout hold", 32'(dout), 32'd1);

        // sparse frame: mem[3]=0101
        for (int i = 0; i < 16; i++) wr(i, (i == 3) ? 4'b0101 : 4'h0);
        for (int p = 0; p < 64; p++) samp(p, p == 63);
        chk("sparse ones", 32'(ones_cnt), 32'd2);
`ifdef FRAME_PARITY_EN
        chk("sparse par", 32'(frame_par), 32'd0);
`endif
        chk("sparse seq_err", 32'(seq_err), 32'd0);

        // sequence break 20 -> 0, then a full frame of 7 ones
        wr(0, 4'h1);
        wr(15, 4'hF);
        for (int p = 0; p <= 20; p++) samp(p, 1'b0);
        samp(0, 1'b0);
        chk("jump seq_err", 32'(seq_err), 32'd1);
        chk("jump ones kept", 32'(ones_cnt), 32'd2);
        chk("jump state", 32'(state_dbg), 32'd1);
        for (int p = 1; p < 64; p++) samp(p, p == 63);
        chk("restart ones", 32'(ones_cnt), 32'd7);
`ifdef FRAME_PARITY_EN
        chk("restart par", 32'(frame_par), 32'd1);
`endif
        chk("seq_err sticky", 32'(seq_err), 32'd1);

        // same-cycle write to the sampled register returns old data
        samp_w(21, 1'b0, 1'b1, 5, 4'hA);
        samp(21, 1'b0);
        chk("p21 new dout", 32'(dout), 32'd1);
        chk("p21 state", 32'(state_dbg), 32'd0);

        // clr mid-frame at p=30
        for (int i = 0; i < 16; i++) wr(i, 4'hF);
        for (int p = 0; p <= 30; p++) samp(p, 1'b0);
        clr = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) mem_m[i] = 4'h0;
        chk("clr dout", 32'(dout), 32'd0);
        chk("clr vld", 32'(dout_vld), 32'd0);
        chk("clr ones", 32'(ones_cnt), 32'd0);
        chk("clr seq_err", 32'(seq_err), 32'd0);
        chk("clr state", 32'(state_dbg), 32'd0);
`ifdef FRAME_PARITY_EN
        chk("clr par", 32'(frame_par), 32'd0);
`endif
        // strobes during clr are ignored
        adv = 1'b1; rg_a = 4'd7; bit_a = 2'd3;
        we = 1'b1; wa = 4'd7; wd = 4'hF;
        @(posedge clk);
        #1;
        adv = 1'b0; we = 1'b0;
        chk("clr adv vld", 32'(dout_vld), 32'd0);
        clr = 1'b0;
        #1;
        samp(31, 1'b0);
        chk("p31 state", 32'(state_dbg), 32'd0);
        for (int i = 0; i < 16; i++) wr(i, 4'hF);
        for (int p = 32; p < 64; p++) samp(p, 1'b0);
        chk("resume ones", 32'(ones_cnt), 32'd0);
        chk("resume state", 32'(state_dbg), 32'd0);
        chk("resume seq_err", 32'(seq_err), 32'd0);
        for (int p = 0; p < 64; p++) samp(p, p == 63);
        chk("final ones", 32'(ones_cnt), 32'd64);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
